// File: rtl/sm_rom_arb_pkg.sv
// Shared constants, types and helpers for the shared instruction-ROM fetch arbiter.
// The bounds check is enabled by defining SM_ROM_ARB_BOUNDS_EN (see sm_rom_arbiter).
package sm_rom_arb_pkg;

    localparam logic [31:0] SM_NOP_INSN  = 32'h0000_0013;
    localparam int          SM_MAX_CORES = 64;

    typedef logic [31:0] insn_t;

    typedef struct packed {
        insn_t data;
        logic  err;
    } sm_rsp_t;

    function automatic int smIdxWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Caller guarantees the vector is one-hot or zero; zero maps to index 0.
    function automatic int smOneHotToIdx(input logic [SM_MAX_CORES-1:0] oneHot);
        int idx;
        idx = 0;
        for (int i = 0; i < SM_MAX_CORES; i++) begin
            if (oneHot[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sm_rom_arbiter_rr.sv
// Rotating-priority encoder: picks the first requester at or after the pointer, modulo N.
// Purely combinational; the pointer itself is owned by the parent.
module sm_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant
);

    always_comb begin : l_search
        logic found;
        int   idx;
        found   = 1'b0;
        idx     = 0;
        o_grant = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(i_ptr) + k) % N;
            if (!found && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_rom_arbiter.sv
// Shares one combinational instruction ROM among N_CORES fetch ports with round-robin grant
// and a registered one-deep response slot. Define SM_ROM_ARB_BOUNDS_EN to return a NOP plus
// rsp_err for addresses >= SIZE.
module sm_rom_arbiter
    import sm_rom_arb_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int SIZE    = 64,
    parameter int ADDR_W  = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_CORES-1:0]          i_req_valid,
    input  logic [N_CORES*ADDR_W-1:0]   i_req_addr,
    output logic [N_CORES-1:0]          o_req_ready,
    output logic [N_CORES-1:0]          o_rsp_valid,
    input  logic [N_CORES-1:0]          i_rsp_ready,
    output logic [31:0]                 o_rsp_data,
    output logic                        o_rsp_err,
    output logic [ADDR_W-1:0]           o_rom_a,
    input  logic [31:0]                 i_rom_rd
);

    localparam int IDX_W = smIdxWidth(N_CORES);

    logic [N_CORES-1:0] r_rspValid;
    insn_t              r_rspData;
    logic               r_rspErr;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;

    logic [N_CORES-1:0] w_cand;
    logic [IDX_W-1:0]   w_candIdx;
    logic [IDX_W-1:0]   w_nextPtr;
    logic               w_ownerReady;
    logic               w_slotFree;
    logic               w_grantEn;
    logic               w_oob;
    sm_rsp_t            w_nextRsp;

    sm_rr_arbiter #(
        .N     (N_CORES),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_cand)
    );

    // The slot can take a new fetch when empty or when its current owner drains it this cycle.
    assign w_ownerReady = |(i_rsp_ready & (N_CORES'(1) << r_owner));
    assign w_slotFree   = ~|r_rspValid | w_ownerReady;
    assign w_grantEn    = w_slotFree & ~i_rst & (|i_req_valid);
    assign o_req_ready  = w_grantEn ? w_cand : '0;

    assign w_candIdx = IDX_W'(smOneHotToIdx(SM_MAX_CORES'(w_cand)));
    assign w_nextPtr = (int'(w_candIdx) == N_CORES - 1) ? '0 : w_candIdx + 1'b1;

    always_comb begin
        o_rom_a = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (w_cand[i]) o_rom_a = i_req_addr[i*ADDR_W +: ADDR_W];
        end
    end

`ifdef SM_ROM_ARB_BOUNDS_EN
    assign w_oob = (64'(o_rom_a) >= 64'(SIZE));
`else
    assign w_oob = 1'b0;
`endif

    assign w_nextRsp.data = w_oob ? SM_NOP_INSN : i_rom_rd;
    assign w_nextRsp.err  = w_oob;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rspValid <= '0;
            r_rspData  <= '0;
            r_rspErr   <= 1'b0;
            r_owner    <= '0;
            r_ptr      <= '0;
        end else if (w_grantEn) begin
            r_rspValid <= w_cand;
            r_rspData  <= w_nextRsp.data;
            r_rspErr   <= w_nextRsp.err;
            r_owner    <= w_candIdx;
            r_ptr      <= w_nextPtr;
        end else if (w_slotFree) begin
            // Drained with nothing new to load: data is kept, valid and error drop.
            r_rspValid <= '0;
            r_rspErr   <= 1'b0;
        end
    end

    assign o_rsp_valid = r_rspValid;
    assign o_rsp_data  = r_rspData;
    assign o_rsp_err   = r_rspErr;

endmodule

// File: tb/tb_sm_rom_arbiter.sv
// Self-checking bench for sm_rom_arbiter: directed vector table, hand-written corner
// sequences and a randomized phase checked against a behavioural round-robin model.
module tb_sm_rom_arbiter;

    localparam int N    = 4;
    localparam int SIZE = 64;
    localparam int AW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    reqValid;
    logic [N*AW-1:0] reqAddr;
    logic [N-1:0]    reqReady;
    logic [N-1:0]    rspValid;
    logic [N-1:0]    rspReady;
    logic [31:0]     rspData;
    logic            rspErr;
    logic [AW-1:0]   romA;
    logic [31:0]     romRd;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: next-priority core, pending response and its owner.
    int          mPtr;
    int          mOwner;
    bit          mPend;
    logic [31:0] mData;
    bit          mErr;
    logic [N-1:0] lastReqReady;

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*AW-1:0] addr;
        logic [N-1:0]    rdy;
        logic [N-1:0]    expReqReady;
        logic [N-1:0]    expRspValid;
        logic [31:0]     expRspData;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    function automatic logic [31:0] romModel(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h0050_0293;
            32'd1:   return 32'h0052_8293;
            32'd2:   return 32'h0e51_afa3;
            32'd3:   return 32'h0ff1_a303;
            32'd4:   return 32'hfe00_0ae3;
            default: return 32'h5A00_0000 ^ a;
        endcase
    endfunction

    assign romRd = romModel(romA);

    sm_rom_arbiter #(
        .N_CORES (N),
        .SIZE    (SIZE),
        .ADDR_W  (AW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (reqValid),
        .i_req_addr  (reqAddr),
        .o_req_ready (reqReady),
        .o_rsp_valid (rspValid),
        .i_rsp_ready (rspReady),
        .o_rsp_data  (rspData),
        .o_rsp_err   (rspErr),
        .o_rom_a     (romA),
        .i_rom_rd    (romRd)
    );

    function automatic bit isOob(input logic [31:0] a);
`ifdef SM_ROM_ARB_BOUNDS_EN
        return a >= SIZE;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] expData(input logic [31:0] a);
        return isOob(a) ? 32'h0000_0013 : romModel(a);
    endfunction

    function automatic logic [N*AW-1:0] packAddr(input logic [31:0] a0, input logic [31:0] a1,
                                                 input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic int modelWinner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(mPtr + k) % N]) return (mPtr + k) % N;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [N*AW-1:0] a,
                                 input logic [N-1:0] rr);
        rst      = r;
        reqValid = v;
        reqAddr  = a;
        rspReady = rr;
    endtask

    // One clock cycle: drive, check combinational outputs mid-cycle, advance model, check registers.
    task automatic stepCycle(input logic r, input logic [N-1:0] v, input logic [N*AW-1:0] a,
                             input logic [N-1:0] rr);
        int           w;
        bit           slotFree;
        bit           grant;
        logic [N-1:0] expReady;
        logic [31:0]  expRomA;
        logic [31:0]  addr;
        applyStimulus(r, v, a, rr);
        @(negedge clk);
        w        = modelWinner(v);
        slotFree = !mPend || rr[mOwner];
        grant    = !r && slotFree && (w >= 0);
        expReady = grant ? N'(1) << w : '0;
        expRomA  = (w >= 0) ? a[w*AW +: AW] : '0;
        lastReqReady = reqReady;
        checkOutput("model.reqReady", 64'(reqReady), 64'(expReady));
        checkOutput("model.romA", 64'(romA), 64'(expRomA));
        @(posedge clk);
        #1;
        if (r) begin
            mPend = 0; mOwner = 0; mPtr = 0; mData = '0; mErr = 0;
        end else if (grant) begin
            addr   = a[w*AW +: AW];
            mPend  = 1;
            mOwner = w;
            mData  = expData(addr);
            mErr   = isOob(addr);
            mPtr   = (w + 1) % N;
        end else if (slotFree) begin
            mPend = 0;
            mErr  = 0;
        end
        checkOutput("model.rspValid", 64'(rspValid), mPend ? 64'(N'(1) << mOwner) : 64'd0);
        checkOutput("model.rspData", 64'(rspData), 64'(mData));
        checkOutput("model.rspErr", 64'(rspErr), 64'(mErr));
    endtask

    function automatic vec_t mkVec(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N-1:0] rr,
                                   input logic [N-1:0] eRdy, input logic [N-1:0] eVal, input logic [31:0] eDat);
        vec_t t;
        t.valid = v; t.addr = a; t.rdy = rr;
        t.expReqReady = eRdy; t.expRspValid = eVal; t.expRspData = eDat;
        return t;
    endfunction

    initial begin
        logic [N*AW-1:0] a0123;
        logic [N-1:0]    prevGrant;
        a0123 = packAddr(0, 1, 2, 3);

        // Directed sequence: single fetch, idle, pointer wrap, 4-core sweep, stall on core 2.
        vecs[0]  = mkVec(4'b0001, packAddr(1, 0, 0, 0), 4'b1111, 4'b0001, 4'b0001, 32'h0052_8293);
        vecs[1]  = mkVec(4'b0000, a0123,                4'b1111, 4'b0000, 4'b0000, 32'h0052_8293);
        vecs[2]  = mkVec(4'b1000, a0123,                4'b1111, 4'b1000, 4'b1000, 32'h0ff1_a303);
        vecs[3]  = mkVec(4'b1111, a0123,                4'b1111, 4'b0001, 4'b0001, 32'h0050_0293);
        vecs[4]  = mkVec(4'b1111, a0123,                4'b1111, 4'b0010, 4'b0010, 32'h0052_8293);
        vecs[5]  = mkVec(4'b1111, a0123,                4'b1111, 4'b0100, 4'b0100, 32'h0e51_afa3);
        vecs[6]  = mkVec(4'b1111, a0123,                4'b1111, 4'b1000, 4'b1000, 32'h0ff1_a303);
        vecs[7]  = mkVec(4'b0100, a0123,                4'b1111, 4'b0100, 4'b0100, 32'h0e51_afa3);
        vecs[8]  = mkVec(4'b1011, a0123,                4'b1011, 4'b0000, 4'b0100, 32'h0e51_afa3);
        vecs[9]  = mkVec(4'b1011, a0123,                4'b1011, 4'b0000, 4'b0100, 32'h0e51_afa3);
        vecs[10] = mkVec(4'b1011, a0123,                4'b1011, 4'b0000, 4'b0100, 32'h0e51_afa3);
        vecs[11] = mkVec(4'b1011, a0123,                4'b1111, 4'b1000, 4'b1000, 32'h0ff1_a303);
        vecs[12] = mkVec(4'b0000, a0123,                4'b1111, 4'b0000, 4'b0000, 32'h0ff1_a303);

        mPtr = 0; mOwner = 0; mPend = 0; mData = '0; mErr = 0;
        applyStimulus(1'b1, '0, '0, '1);
        @(posedge clk);
        #1;

        $display("[TB] reset state");
        stepCycle(1'b1, 4'b1111, a0123, 4'b1111);
        checkOutput("reset.reqReady", 64'(lastReqReady), 64'd0);
        checkOutput("reset.rspValid", 64'(rspValid), 64'd0);
        checkOutput("reset.rspData", 64'(rspData), 64'd0);
        checkOutput("reset.rspErr", 64'(rspErr), 64'd0);

        $display("[TB] directed vector table");
        for (int i = 0; i < 13; i++) begin
            stepCycle(1'b0, vecs[i].valid, vecs[i].addr, vecs[i].rdy);
            checkOutput($sformatf("vec%0d.reqReady", i), 64'(lastReqReady), 64'(vecs[i].expReqReady));
            checkOutput($sformatf("vec%0d.rspValid", i), 64'(rspValid), 64'(vecs[i].expRspValid));
            checkOutput($sformatf("vec%0d.rspData", i), 64'(rspData), 64'(vecs[i].expRspData));
        end

        $display("[TB] two-core alternation");
        prevGrant = '0;
        for (int k = 0; k < 8; k++) begin
            stepCycle(1'b0, 4'b1001, packAddr(4, 0, 0, 2), 4'b1111);
            checkOutput($sformatf("alt%0d.grant", k), 64'(lastReqReady), (k % 2 == 0) ? 64'h1 : 64'h8);
            checkOutput($sformatf("alt%0d.data", k), 64'(rspData),
                        (k % 2 == 0) ? 64'h0000_0000_fe00_0ae3 : 64'h0000_0000_0e51_afa3);
            if (k > 0) checkOutput($sformatf("alt%0d.repeat", k), 64'(lastReqReady == prevGrant), 64'd0);
            prevGrant = lastReqReady;
        end

        $display("[TB] reset with a pending response");
        stepCycle(1'b0, 4'b0010, a0123, 4'b1111);
        checkOutput("rstmid.pending", 64'(rspValid), 64'h2);
        stepCycle(1'b1, 4'b1111, a0123, 4'b0000);
        checkOutput("rstmid.reqReady", 64'(lastReqReady), 64'd0);
        checkOutput("rstmid.rspValid", 64'(rspValid), 64'd0);
        checkOutput("rstmid.rspData", 64'(rspData), 64'd0);
        stepCycle(1'b0, 4'b0110, a0123, 4'b1111);
        checkOutput("rstmid.firstGrant", 64'(lastReqReady), 64'h2);
        checkOutput("rstmid.firstData", 64'(rspData), 64'h0052_8293);

        $display("[TB] address bounds");
        stepCycle(1'b0, 4'b0010, packAddr(0, 64, 0, 0), 4'b1111);
`ifdef SM_ROM_ARB_BOUNDS_EN
        checkOutput("bounds.oobData", 64'(rspData), 64'h0000_0013);
        checkOutput("bounds.oobErr", 64'(rspErr), 64'd1);
`else
        checkOutput("bounds.oobData", 64'(rspData), 64'(32'h5A00_0040));
        checkOutput("bounds.oobErr", 64'(rspErr), 64'd0);
`endif
        stepCycle(1'b0, 4'b0010, packAddr(0, 4, 0, 0), 4'b1111);
        checkOutput("bounds.inData", 64'(rspData), 64'hfe00_0ae3);
        checkOutput("bounds.inErr", 64'(rspErr), 64'd0);
        stepCycle(1'b0, 4'b0000, a0123, 4'b1111);
        checkOutput("bounds.idleValid", 64'(rspValid), 64'd0);
        checkOutput("bounds.idleErr", 64'(rspErr), 64'd0);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            logic [N*AW-1:0] ra;
            for (int i = 0; i < N; i++) ra[i*AW +: AW] = 32'($urandom_range(0, 70));
            stepCycle($urandom_range(0, 49) == 0, N'($urandom), ra, N'($urandom | $urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
